// File: rtl/button_event_decoder.sv
// button_event_decoder
// Turns debounced, clk-synchronous button levels into single-cycle events:
// press, release, click (short press), long-press and auto-repeat.
// Each channel has its own 4-state FSM and hold counter; all outputs are
// registered.
module button_event_decoder #(
    parameter int N_BUTTONS     = 5,
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int REPEAT_EN     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_BUTTONS-1:0] buttons,
    output logic [N_BUTTONS-1:0] press_o,
    output logic [N_BUTTONS-1:0] release_o,
    output logic [N_BUTTONS-1:0] click_o,
    output logic [N_BUTTONS-1:0] long_o,
    output logic [N_BUTTONS-1:0] repeat_o,
    output logic [N_BUTTONS-1:0] held_o
);

    localparam int CNT_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Counter value seen on the edge that fires long_o / repeat_o.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_WAIT_LOW,
        ST_IDLE,
        ST_HELD,
        ST_LONG
    } state_e;

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
        state_e           state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             press_q;
        logic             release_q;
        logic             click_q;
        logic             long_q;
        logic             repeat_q;
        logic             held_q;

        // Per-channel FSM, hold counter and registered event pulses.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q   <= ST_WAIT_LOW;
                cnt_q     <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                click_q   <= 1'b0;
                long_q    <= 1'b0;
                repeat_q  <= 1'b0;
                held_q    <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                click_q   <= 1'b0;
                long_q    <= 1'b0;
                repeat_q  <= 1'b0;
                case (state_q)
                    ST_WAIT_LOW: begin
                        // Lockout: a button held through reset must be let go first.
                        held_q <= 1'b0;
                        cnt_q  <= '0;
                        if (!buttons[i]) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_IDLE: begin
                        cnt_q <= '0;
                        if (buttons[i]) begin
                            state_q <= ST_HELD;
                            press_q <= 1'b1;
                            held_q  <= 1'b1;
                        end else begin
                            held_q <= 1'b0;
                        end
                    end
                    ST_HELD: begin
                        // Release is checked first so it wins over a coincident long press.
                        if (!buttons[i]) begin
                            state_q   <= ST_IDLE;
                            cnt_q     <= '0;
                            release_q <= 1'b1;
                            click_q   <= 1'b1;
                            held_q    <= 1'b0;
                        end else if (cnt_q == LONG_LAST) begin
                            state_q <= ST_LONG;
                            cnt_q   <= '0;
                            long_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_LONG: begin
                        if (!buttons[i]) begin
                            state_q   <= ST_IDLE;
                            cnt_q     <= '0;
                            release_q <= 1'b1;
                            held_q    <= 1'b0;
                        end else if (REPEAT_EN != 0) begin
                            if (cnt_q == REPEAT_LAST) begin
                                cnt_q    <= '0;
                                repeat_q <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_WAIT_LOW;
                        cnt_q   <= '0;
                        held_q  <= 1'b0;
                    end
                endcase
            end
        end

        assign press_o[i]   = press_q;
        assign release_o[i] = release_q;
        assign click_o[i]   = click_q;
        assign long_o[i]    = long_q;
        assign repeat_o[i]  = repeat_q;
        assign held_o[i]    = held_q;
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// Testbench for button_event_decoder: scenario tasks queue per-cycle stimulus
// and expected output vectors, then replay them one clock at a time.
module tb_button_event_decoder;

    localparam int NB = 5;
    localparam int LC = 8;
    localparam int RC = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] buttons = '0;

    logic [NB-1:0] press_a, release_a, click_a, long_a, repeat_a, held_a;
    logic [NB-1:0] press_b, release_b, click_b, long_b, repeat_b, held_b;

    typedef struct packed {
        logic [NB-1:0] press;
        logic [NB-1:0] rel;
        logic [NB-1:0] click;
        logic [NB-1:0] lng;
        logic [NB-1:0] rpt;
        logic [NB-1:0] held;
    } ev_t;

    ev_t obs_a, obs_b;
    assign obs_a = {press_a, release_a, click_a, long_a, repeat_a, held_a};
    assign obs_b = {press_b, release_b, click_b, long_b, repeat_b, held_b};

    int vectors = 0;
    int errors  = 0;

    logic [NB-1:0] stim_q[$];
    ev_t           exp_q[$];

    button_event_decoder #(
        .N_BUTTONS    (NB),
        .LONG_CYCLES  (LC),
        .REPEAT_CYCLES(RC),
        .REPEAT_EN    (1)
    ) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .buttons  (buttons),
        .press_o  (press_a),
        .release_o(release_a),
        .click_o  (click_a),
        .long_o   (long_a),
        .repeat_o (repeat_a),
        .held_o   (held_a)
    );

    button_event_decoder #(
        .N_BUTTONS    (NB),
        .LONG_CYCLES  (LC),
        .REPEAT_CYCLES(RC),
        .REPEAT_EN    (0)
    ) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .buttons  (buttons),
        .press_o  (press_b),
        .release_o(release_b),
        .click_o  (click_b),
        .long_o   (long_b),
        .repeat_o (repeat_b),
        .held_o   (held_b)
    );

    always #5 clk = ~clk;

    // Button 0 held through reset: no press until released and pressed again.
    task automatic test_reset();
        ev_t e;
        logic [NB-1:0] s;
        rst_n   = 1'b0;
        buttons = 5'b00001;
        #12;
        vectors++;
        if (obs_a !== ev_t'('0)) begin
            errors++;
            $display("FAIL reset_a: got %h expected 0", obs_a);
        end
        vectors++;
        if (obs_b !== ev_t'('0)) begin
            errors++;
            $display("FAIL reset_b: got %h expected 0", obs_b);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            s = (k < 5 || k == 7) ? 5'b00001 : 5'b00000;
            e = '0;
            if (k == 7) begin
                e.press[0] = 1'b1;
                e.held[0]  = 1'b1;
            end
            if (k == 8) begin
                e.rel[0]   = 1'b1;
                e.click[0] = 1'b1;
            end
            stim_q.push_back(s);
            exp_q.push_back(e);
        end
        for (int k = 0; exp_q.size() > 0; k++) begin
            buttons = stim_q.pop_front();
            e = exp_q.pop_front();
            @(posedge clk);
            #1;
            vectors++;
            if (obs_a !== e) begin
                errors++;
                $display("FAIL reset_lockout k=%0d: got %h expected %h", k, obs_a, e);
            end
        end
    endtask

    // Short press on button 1: click with release, no long.
    task automatic test_click();
        ev_t e;
        logic [NB-1:0] s;
        for (int k = 0; k < 7; k++) begin
            s = '0;
            e = '0;
            if (k <= 3) begin
                s[1]      = 1'b1;
                e.held[1] = 1'b1;
            end
            if (k == 0) e.press[1] = 1'b1;
            if (k == 4) begin
                e.rel[1]   = 1'b1;
                e.click[1] = 1'b1;
            end
            stim_q.push_back(s);
            exp_q.push_back(e);
        end
        for (int k = 0; exp_q.size() > 0; k++) begin
            buttons = stim_q.pop_front();
            e = exp_q.pop_front();
            @(posedge clk);
            #1;
            vectors++;
            if (obs_a !== e) begin
                errors++;
                $display("FAIL click k=%0d: got %h expected %h", k, obs_a, e);
            end
        end
    endtask

    // Long hold on button 2: long at P+8, repeats at P+11,14,17,20, no click.
    task automatic test_long_repeat();
        ev_t e;
        logic [NB-1:0] s;
        for (int k = 0; k < 24; k++) begin
            s = '0;
            e = '0;
            if (k <= 20) begin
                s[2]      = 1'b1;
                e.held[2] = 1'b1;
            end
            if (k == 0) e.press[2] = 1'b1;
            if (k == LC) e.lng[2] = 1'b1;
            if (k == 11 || k == 14 || k == 17 || k == 20) e.rpt[2] = 1'b1;
            if (k == 21) e.rel[2] = 1'b1;
            stim_q.push_back(s);
            exp_q.push_back(e);
        end
        for (int k = 0; exp_q.size() > 0; k++) begin
            buttons = stim_q.pop_front();
            e = exp_q.pop_front();
            @(posedge clk);
            #1;
            vectors++;
            if (obs_a !== e) begin
                errors++;
                $display("FAIL long_repeat k=%0d: got %h expected %h", k, obs_a, e);
            end
        end
    endtask

    // Button 3 released on the very edge long would register: release wins.
    task automatic test_long_cancel();
        ev_t e;
        logic [NB-1:0] s;
        for (int k = 0; k < 11; k++) begin
            s = '0;
            e = '0;
            if (k < LC) begin
                s[3]      = 1'b1;
                e.held[3] = 1'b1;
            end
            if (k == 0) e.press[3] = 1'b1;
            if (k == LC) begin
                e.rel[3]   = 1'b1;
                e.click[3] = 1'b1;
            end
            stim_q.push_back(s);
            exp_q.push_back(e);
        end
        for (int k = 0; exp_q.size() > 0; k++) begin
            buttons = stim_q.pop_front();
            e = exp_q.pop_front();
            @(posedge clk);
            #1;
            vectors++;
            if (obs_a !== e) begin
                errors++;
                $display("FAIL long_cancel k=%0d: got %h expected %h", k, obs_a, e);
            end
        end
    endtask

    // 1-cycle glitch then immediate re-press on button 0.
    task automatic test_back_to_back();
        ev_t e;
        logic [NB-1:0] s;
        for (int k = 0; k < 5; k++) begin
            s = (k == 0 || k == 2) ? 5'b00001 : 5'b00000;
            e = '0;
            if (k == 0 || k == 2) begin
                e.press[0] = 1'b1;
                e.held[0]  = 1'b1;
            end
            if (k == 1 || k == 3) begin
                e.rel[0]   = 1'b1;
                e.click[0] = 1'b1;
            end
            stim_q.push_back(s);
            exp_q.push_back(e);
        end
        for (int k = 0; exp_q.size() > 0; k++) begin
            buttons = stim_q.pop_front();
            e = exp_q.pop_front();
            @(posedge clk);
            #1;
            vectors++;
            if (obs_a !== e) begin
                errors++;
                $display("FAIL back_to_back k=%0d: got %h expected %h", k, obs_a, e);
            end
        end
    endtask

    // All buttons at once, then reset mid-hold aborts silently.
    task automatic test_all_and_reset();
        ev_t e;
        logic [NB-1:0] s;
        for (int k = 0; k < 4; k++) begin
            e = '0;
            e.held = '1;
            if (k == 0) e.press = '1;
            stim_q.push_back('1);
            exp_q.push_back(e);
        end
        for (int k = 0; exp_q.size() > 0; k++) begin
            buttons = stim_q.pop_front();
            e = exp_q.pop_front();
            @(posedge clk);
            #1;
            vectors++;
            if (obs_a !== e) begin
                errors++;
                $display("FAIL all_press k=%0d: got %h expected %h", k, obs_a, e);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (obs_a !== ev_t'('0)) begin
            errors++;
            $display("FAIL async_reset: got %h expected 0", obs_a);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            s = (k <= 2 || k == 4) ? '1 : '0;
            e = '0;
            if (k == 4) begin
                e.press = '1;
                e.held  = '1;
            end
            if (k == 5) begin
                e.rel   = '1;
                e.click = '1;
            end
            stim_q.push_back(s);
            exp_q.push_back(e);
        end
        for (int k = 0; exp_q.size() > 0; k++) begin
            buttons = stim_q.pop_front();
            e = exp_q.pop_front();
            @(posedge clk);
            #1;
            vectors++;
            if (obs_a !== e) begin
                errors++;
                $display("FAIL post_reset k=%0d: got %h expected %h", k, obs_a, e);
            end
        end
    endtask

    // Repeat disabled: single long, held stays high until release.
    task automatic test_no_repeat();
        ev_t e;
        logic [NB-1:0] s;
        for (int k = 0; k < 33; k++) begin
            s = '0;
            e = '0;
            if (k < 30) begin
                s[4]      = 1'b1;
                e.held[4] = 1'b1;
            end
            if (k == 0) e.press[4] = 1'b1;
            if (k == LC) e.lng[4] = 1'b1;
            if (k == 30) e.rel[4] = 1'b1;
            stim_q.push_back(s);
            exp_q.push_back(e);
        end
        for (int k = 0; exp_q.size() > 0; k++) begin
            buttons = stim_q.pop_front();
            e = exp_q.pop_front();
            @(posedge clk);
            #1;
            vectors++;
            if (obs_b !== e) begin
                errors++;
                $display("FAIL no_repeat k=%0d: got %h expected %h", k, obs_b, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_click();
        test_long_repeat();
        test_long_cancel();
        test_back_to_back();
        test_all_and_reset();
        test_no_repeat();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
